inst_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents the fetched word as inst_code with a valid/ready handshake.
- Computes the next PC from the redirect inputs (branch, J/JAL, JR) supplied by the execute/control logic.

---
 rtl/inst_fetch.sv | 128 ++++++++++++
 tb/tb_inst_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, imem req/ack read, valid/ready hand-off to decode, redirect-based next-PC.
// Optional misaligned-target trap enabled by defining INST_FETCH_MISALIGN_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h00400000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_code,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_idx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        err_timeout
`ifdef INST_FETCH_MISALIGN_EN
    ,
    output logic        misalign
`endif
);

    localparam int unsigned CNT_W = $clog2(IMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        pc4;
    logic [31:0]        br_off;
    logic [31:0]        next_pc;
    logic               accept;

    assign imem_addr = pc;

    // Redirect priority: jr > jmp > branch > sequential.
    always_comb begin
        pc4     = pc + 32'd4;
        br_off  = {{14{br_imm[15]}}, br_imm, 2'b00};
        accept  = (state == S_HOLD) && inst_valid && inst_ready;
        next_pc = pc4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jmp) begin
            next_pc = {pc4[31:28], jmp_idx, 2'b00};
        end else if (br_taken) begin
            next_pc = pc4 + br_off;
        end
    end

    // Single-process FSM; imem_req is raised one cycle ahead of leaving REQ so it is a clean register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inst_code   <= 32'd0;
            inst_valid  <= 1'b0;
            imem_req    <= 1'b0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
`ifdef INST_FETCH_MISALIGN_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        inst_code  <= imem_rdata;
                        inst_valid <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= S_HOLD;
                    end else begin
                        if (wait_cnt != CNT_W'(IMEM_TIMEOUT)) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                        if (wait_cnt >= CNT_W'(IMEM_TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        inst_valid <= 1'b0;
`ifdef INST_FETCH_MISALIGN_EN
                        // Misaligned target: keep pc, drop valid and park here for good.
                        if (next_pc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_REQ;
                        end
`else
                        pc       <= next_pc & ~32'd3;
                        imem_req <= 1'b1;
                        state    <= S_REQ;
`endif
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed redirect/timeout/reset steps plus randomized fetch traffic
// checked against a next-PC reference computed from the architectural rules.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_code;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jmp;
    logic [25:0] jmp_idx;
    logic        jr;
    logic [31:0] jr_target;
    logic        err_timeout;
`ifdef INST_FETCH_MISALIGN_EN
    logic        misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_code   (inst_code),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .pc          (pc),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .jmp         (jmp),
        .jmp_idx     (jmp_idx),
        .jr          (jr),
        .jr_target   (jr_target),
        .err_timeout (err_timeout)
`ifdef INST_FETCH_MISALIGN_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC: pc+4, then jr / jump-region / signed word-offset branch.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic b, input logic [15:0] imm,
                                             input logic j, input logic [25:0] idx,
                                             input logic r, input logic [31:0] tgt);
        logic [31:0] seq;
        logic [31:0] res;
        seq = p + 32'd4;
        if (r)      res = tgt;
        else if (j) res = (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
        else if (b) res = seq + 32'(int'($signed(imm)) * 4);
        else        res = seq;
`ifndef INST_FETCH_MISALIGN_EN
        res = res & 32'hFFFF_FFFC;
`endif
        return res;
    endfunction

    task automatic randomize_redirects;
        br_taken  = 1'($urandom);
        br_imm    = 16'($urandom);
        jmp       = 1'($urandom);
        jmp_idx   = 26'($urandom);
        jr        = 1'($urandom);
        jr_target = $urandom;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int k = 0;
        while (imem_req !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("req_addr", imem_addr, exp_addr);
    endtask

    // One full transaction: request, ack after lat cycles, hold for hold cycles, accept with given redirects.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int lat, input int hold,
                         input logic b, input logic [15:0] imm, input logic j, input logic [25:0] idx,
                         input logic r, input logic [31:0] tgt, output logic [31:0] nxt);
        wait_req(exp_addr);
        tick();
        check("wait_req_low", 32'(imem_req), 32'd0);
        repeat (lat) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_code", inst_code, data);
        check("hold_pc", pc, exp_addr);
        for (int h = 0; h < hold; h++) begin
            randomize_redirects();
            tick();
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_code", inst_code, data);
            check("stall_pc", pc, exp_addr);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        inst_ready = 1'b1;
        br_taken = b; br_imm = imm; jmp = j; jmp_idx = idx; jr = r; jr_target = tgt;
        tick();
        inst_ready = 1'b0;
        randomize_redirects();
        check("post_accept_valid", 32'(inst_valid), 32'd0);
        nxt = ref_next(exp_addr, b, imm, j, idx, r, tgt);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] nxt;
        logic [31:0] tgt;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        br_taken = 1'b0; br_imm = 16'd0; jmp = 1'b0; jmp_idx = 26'd0; jr = 1'b0; jr_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_code", inst_code, 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
`ifdef INST_FETCH_MISALIGN_EN
        check("rst_misalign", 32'(misalign), 32'd0);
`endif
        rst = 1'b0;

        // Directed: sequential, stall, redirect priority, jump, branch both signs.
        fetch(32'h00400000, 32'h20080005, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, nxt);
        fetch(nxt, 32'h11111111, 0, 5, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, nxt);
        check("seq_after_stall", nxt, 32'h00400008);
        fetch(nxt, 32'h22222222, 1, 0, 1'b1, 16'h0001, 1'b1, 26'h0000001, 1'b1, 32'h00400100, nxt);
        fetch(nxt, 32'h33333333, 0, 1, 1'b0, 16'h0, 1'b1, 26'h0100040, 1'b0, 32'h0, nxt);
        fetch(nxt, 32'h44444444, 2, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h00400010, nxt);
        fetch(nxt, 32'h55555555, 0, 0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0, nxt);
        check("br_back_ref", nxt, 32'h00400004);
        fetch(nxt, 32'h66666666, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h00400010, nxt);
        fetch(nxt, 32'h77777777, 0, 0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0, nxt);
        check("br_fwd_ref", nxt, 32'h00400020);
        fetch(nxt, 32'h88888888, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFFFFFC, nxt);
        fetch(nxt, 32'h99999999, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, nxt);
        check("wrap_ref", nxt, 32'h00000000);

        // Randomized traffic against the reference next-PC.
        for (int i = 0; i < 40; i++) begin
            tgt = $urandom;
`ifdef INST_FETCH_MISALIGN_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            fetch(nxt, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  1'($urandom), 16'($urandom), 1'($urandom), 26'($urandom), 1'($urandom), tgt, nxt);
        end

        // Timeout: 16 silent WAIT cycles raise a sticky error; a late ack still completes.
        wait_req(nxt);
        addr = nxt;
        tick();
        repeat (15) tick();
        check("err_before", 32'(err_timeout), 32'd0);
        tick();
        check("err_set", 32'(err_timeout), 32'd1);
        repeat (4) tick();
        check("err_sticky", 32'(err_timeout), 32'd1);
        check("err_still_wait", 32'(inst_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
        tick();
        imem_ack = 1'b0;
        check("late_ack_valid", 32'(inst_valid), 32'd1);
        check("late_ack_code", inst_code, 32'hCAFEF00D);
        check("late_ack_pc", pc, addr);
        br_taken = 1'b0; jmp = 1'b0; jr = 1'b0; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("err_kept", 32'(err_timeout), 32'd1);

        // Asynchronous reset in WAIT, then a stray ack while in REQ.
        wait_req(ref_next(addr, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0));
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_err", 32'(err_timeout), 32'd0);
        check("arst_pc", pc, RESET_PC);
        check("arst_code", inst_code, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0;
        check("stray_ack_valid", 32'(inst_valid), 32'd0);
        check("stray_ack_code", inst_code, 32'd0);
        fetch(RESET_PC, 32'h0BADC0DE, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, nxt);

        // Misaligned jr target.
`ifdef INST_FETCH_MISALIGN_EN
        addr = nxt;
        fetch(nxt, 32'h12345678, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h00400102, nxt);
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_pc", pc, addr);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("mis_no_req", 32'(imem_req), 32'd0);
        end
        check("mis_parked_valid", 32'(inst_valid), 32'd0);
        check("mis_sticky", 32'(misalign), 32'd1);
`else
        fetch(nxt, 32'h12345678, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h00400102, nxt);
        check("force_align_ref", nxt, 32'h00400100);
        wait_req(nxt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
